// File: rtl/eth_axi_tx_framer.sv
// AXI4-Lite programmed TX word FIFO serialised into an AXI-Stream byte frame for a MAC.
// Define ETH_AXI_TX_IRQ_EN to add the frame_irq output and the CTRL.IRQ_MASK bit.
module eth_axi_tx_framer #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [7:0]                      M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST
`ifdef ETH_AXI_TX_IRQ_EN
  ,
  output logic                            frame_irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_LEN    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t r_state, w_state_nxt;

  // AXI-Lite channel state
  logic                          r_awready;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  // Registers
  logic        r_enable;
  logic        r_pending;
  logic [10:0] r_frame_len;
  logic        w_irq_mask_rd;

  // FIFO
  logic [31:0]   r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_full, w_empty, w_push, w_pop, w_flush;

  // Serialiser
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic [10:0] r_remain;
  logic        w_start, w_tvalid, w_frame_done;

  // Write decode
  logic                          w_wr_fire, w_rd_fire;
  logic [1:0]                    w_wr_reg;
  logic                          w_sel_ctrl, w_sel_txd, w_sel_len;
  logic [10:0]                   w_len_merged;
  logic                          w_len_accept;
  logic [1:0]                    w_bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic                          w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                      S_AXI_WDATA, S_AXI_WSTRB};

  assign w_wr_fire  = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_rd_fire  = r_arready && S_AXI_ARVALID;
  assign w_wr_reg   = S_AXI_AWADDR[3:2];
  assign w_sel_ctrl = w_wr_fire && (w_wr_reg == REG_CTRL);
  assign w_sel_txd  = w_wr_fire && (w_wr_reg == REG_TXDATA);
  assign w_sel_len  = w_wr_fire && (w_wr_reg == REG_LEN);

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);

  // A pop in the same cycle frees a slot, so a push at full is still accepted
  assign w_push  = w_sel_txd && (!w_full || w_pop);
  assign w_flush = w_sel_ctrl && S_AXI_WSTRB[0] && S_AXI_WDATA[1] && (r_state == S_IDLE);

  assign w_len_merged = {S_AXI_WSTRB[1] ? S_AXI_WDATA[10:8] : r_frame_len[10:8],
                         S_AXI_WSTRB[0] ? S_AXI_WDATA[7:0]  : r_frame_len[7:0]};
  assign w_len_accept = w_sel_len && !r_pending && (w_len_merged != '0);

  always_comb begin
    w_bresp = RESP_OKAY;
    if (w_sel_txd && !w_push)
      w_bresp = RESP_SLVERR;
    if (w_sel_len && r_pending && (w_len_merged != '0))
      w_bresp = RESP_SLVERR;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
    end else begin
      r_awready <= !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_enable    <= 1'b0;
      r_frame_len <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_sel_ctrl && S_AXI_WSTRB[0])
        r_enable <= S_AXI_WDATA[0];
      if (w_len_accept)
        r_frame_len <= w_len_merged;
      if (w_flush || w_frame_done)
        r_pending <= 1'b0;
      else if (w_len_accept)
        r_pending <= 1'b1;
    end
  end

`ifdef ETH_AXI_TX_IRQ_EN
  logic r_irq_mask;
  logic r_irq;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_irq_mask <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_sel_ctrl && S_AXI_WSTRB[0])
        r_irq_mask <= S_AXI_WDATA[2];
      r_irq <= w_frame_done && !r_irq_mask;
    end
  end

  assign w_irq_mask_rd = r_irq_mask;
  assign frame_irq     = r_irq;
`else
  assign w_irq_mask_rd = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_push)
      r_fifo_mem[r_wr_ptr] <= S_AXI_WDATA[31:0];
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_pop        = 1'b0;
    w_tvalid     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_enable && r_pending && !w_empty) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_tvalid = 1'b1;
        if (M_AXIS_TREADY) begin
          // Final byte ends the frame; unsent bytes of the current word are dropped
          if (r_remain == 11'd1) begin
            w_frame_done = 1'b1;
            w_state_nxt  = S_IDLE;
          end else if (r_idx == 2'd3) begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_shift  <= '0;
      r_idx    <= '0;
      r_remain <= '0;
    end else begin
      if (w_start)
        r_remain <= r_frame_len;
      if (w_pop) begin
        r_shift <= r_fifo_mem[r_rd_ptr];
        r_idx   <= '0;
      end
      if (w_tvalid && M_AXIS_TREADY) begin
        r_remain <= r_remain - 11'd1;
        r_idx    <= r_idx + 2'd1;
      end
    end
  end

  always_comb begin
    case (r_idx)
      2'd0:    M_AXIS_TDATA = r_shift[7:0];
      2'd1:    M_AXIS_TDATA = r_shift[15:8];
      2'd2:    M_AXIS_TDATA = r_shift[23:16];
      default: M_AXIS_TDATA = r_shift[31:24];
    endcase
  end

  assign M_AXIS_TVALID = w_tvalid;
  assign M_AXIS_TLAST  = w_tvalid && (r_remain == 11'd1);

  always_comb begin
    w_rdata = '0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL:   w_rdata[2:0] = {w_irq_mask_rd, 1'b0, r_enable};
      REG_STATUS: begin
        w_rdata[LW-1:0] = r_level;
        w_rdata[16]     = w_full;
        w_rdata[17]     = w_empty;
        w_rdata[18]     = (r_state != S_IDLE);
        w_rdata[19]     = r_pending;
      end
      REG_LEN:    w_rdata[10:0] = r_frame_len;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_eth_axi_tx_framer.sv
// Scoreboard bench for eth_axi_tx_framer: expected stream bytes queued at stimulus time,
// compared as the byte monitor collects them. IRQ scenario runs when ETH_AXI_TX_IRQ_EN is defined.
`timescale 1ns/1ps
module tb_eth_axi_tx_framer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
`ifdef ETH_AXI_TX_IRQ_EN
  logic        irq;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [8:0] q_exp [$];
  logic [8:0] q_got [$];
  int unsigned stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  logic       prev_l = 1'b0;

  eth_axi_tx_framer #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast)
`ifdef ETH_AXI_TX_IRQ_EN
    , .frame_irq(irq)
`endif
  );

  // Byte monitor: records every accepted byte and any change of a stalled beat
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!tvalid || tdata !== prev_d || tlast !== prev_l))
        stall_viol <= stall_viol + 1;
      if (tvalid && tready)
        q_got.push_back({tlast, tdata});
      prev_stall <= tvalid && !tready;
      prev_d     <= tdata;
      prev_l     <= tlast;
    end
  end

`ifdef ETH_AXI_TX_IRQ_EN
  int unsigned irq_good = 0;
  int unsigned irq_bad = 0;
  logic        prev_last_hs = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (irq && prev_last_hs) irq_good <= irq_good + 1;
      else if (irq)            irq_bad  <= irq_bad + 1;
      prev_last_hs <= tvalid && tready && tlast;
    end
  end
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int unsigned n = 0;
    resp = 2'bxx;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 50);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin
      n_checks++; n_fail++;
      $display("FAIL axi_write_timeout addr=%h got=no_bvalid required=bvalid", a);
    end else begin
      resp = bresp;
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int unsigned n = 0;
    d = 'x;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin
      n_checks++; n_fail++;
      $display("FAIL axi_read_timeout addr=%h got=no_rvalid required=rvalid", a);
    end else begin
      d = rdata;
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic wait_bytes(input int unsigned n, input int unsigned budget, output bit ok);
    int unsigned c = 0;
    while (q_got.size() < n && c < budget) begin @(negedge clk); c++; end
    ok = (q_got.size() >= n);
  endtask

  function automatic void exp_push(input logic [31:0] w, input int unsigned nb, input bit fin);
    for (int unsigned i = 0; i < nb; i++)
      q_exp.push_back({fin && (i == nb - 1), w[8*i +: 8]});
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    #190;
    n_checks++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp} !== '0) begin
      n_fail++;
      $display("FAIL reset_axi_ctl got=%b required=0", {awready, wready, bvalid, bresp, arready, rvalid, rresp});
    end
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h required=0", rdata); end
    n_checks++;
    if ({tvalid, tdata, tlast} !== '0) begin
      n_fail++; $display("FAIL reset_stream got=%b required=0", {tvalid, tdata, tlast});
    end
`ifdef ETH_AXI_TX_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b required=0", irq); end
`endif
    #10;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    axi_read(4'h4, d);
    n_checks++;
    if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL reset_status got=%h required=00020000", d); end
    axi_read(4'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got=%h required=0", d); end
    axi_read(4'hC, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_len got=%h required=0", d); end
  endtask

  task automatic test_basic_frame();
    logic [1:0] r;
    logic [31:0] d;
    logic [8:0] e, g;
    bit ok;
    tready = 1'b1;
    exp_push(32'h4433_2211, 4, 1'b0);
    exp_push(32'h0000_0055, 1, 1'b1);
    axi_write(4'h8, 32'h4433_2211, 4'hF, r);
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL basic_push0_resp got=%b required=00", r); end
    axi_write(4'h8, 32'h0000_0055, 4'hF, r);
    axi_write(4'hC, 32'd5, 4'hF, r);
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL basic_len_resp got=%b required=00", r); end
    axi_write(4'h0, 32'h1, 4'hF, r);
    wait_bytes(5, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout got=%0d required=5 bytes", q_got.size()); end
    for (int i = 0; i < 5; i++) begin
      e = q_exp.pop_front();
      g = (q_got.size() > 0) ? q_got.pop_front() : 9'h1FF;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL basic_byte%0d got=%h required=%h", i, g, e); end
    end
    repeat (4) @(posedge clk);
    axi_read(4'h4, d);
    n_checks++;
    if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL basic_status got=%h required=00020000", d); end
  endtask

  task automatic test_fifo_full();
    logic [1:0] r;
    logic [31:0] d;
    int unsigned n_ok = 0;
    axi_write(4'h0, 32'h0, 4'hF, r);
    for (int i = 0; i < DEPTH; i++) begin
      axi_write(4'h8, 32'hA000_0000 + i, 4'hF, r);
      if (r === 2'b00) n_ok++;
    end
    n_checks++;
    if (n_ok != DEPTH) begin n_fail++; $display("FAIL full_okay_count got=%0d required=%0d", n_ok, DEPTH); end
    axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, r);
    n_checks++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL full_overflow_resp got=%b required=10", r); end
    axi_read(4'h4, d);
    n_checks++;
    if (d !== 32'h0001_0010) begin n_fail++; $display("FAIL full_status got=%h required=00010010", d); end
    axi_read(4'h8, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read got=%h required=0", d); end
  endtask

  task automatic test_len_pending_flush();
    logic [1:0] r;
    logic [31:0] d;
    axi_write(4'hC, 32'd3, 4'hF, r);
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL len_first_resp got=%b required=00", r); end
    axi_write(4'hC, 32'd3, 4'hF, r);
    n_checks++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL len_second_resp got=%b required=10", r); end
    axi_read(4'hC, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL len_readback got=%h required=3", d); end
    axi_write(4'h0, 32'h1, 4'h0, r);
    axi_read(4'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_wstrb0 got=%h required=0", d); end
    axi_write(4'h0, 32'h2, 4'hF, r);
    axi_read(4'h4, d);
    n_checks++;
    if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL flush_status got=%h required=00020000", d); end
    axi_read(4'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL flush_ctrl_read got=%h required=0", d); end
    axi_write(4'hC, 32'd0, 4'hF, r);
    axi_read(4'h4, d);
    n_checks++;
    if (r !== 2'b00 || d[19] !== 1'b0) begin
      n_fail++; $display("FAIL len_zero got=resp%b pend%b required=resp00 pend0", r, d[19]);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] r;
    logic [31:0] w0, w1;
    logic [8:0] e, g;
    bit ok, done;
    w0 = $urandom; w1 = $urandom;
    exp_push(w0, 4, 1'b0);
    exp_push(w1, 4, 1'b1);
    axi_write(4'h8, w0, 4'hF, r);
    axi_write(4'h8, w1, 4'hF, r);
    axi_write(4'hC, 32'd8, 4'hF, r);
    stall_viol = 0;
    done = 1'b0;
    tready = 1'b1;
    fork
      begin
        for (int k = 0; k < 400 && !done; k++) begin @(posedge clk); #1 tready = ~tready; end
      end
      begin
        axi_write(4'h0, 32'h1, 4'hF, r);
        wait_bytes(8, 300, ok);
        done = 1'b1;
      end
    join
    @(posedge clk); #1 tready = 1'b1;
    repeat (6) @(posedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout got=%0d required=8 bytes", q_got.size()); end
    n_checks++;
    if (q_got.size() != 8) begin n_fail++; $display("FAIL bp_byte_count got=%0d required=8", q_got.size()); end
    for (int i = 0; i < 8; i++) begin
      e = q_exp.pop_front();
      g = (q_got.size() > 0) ? q_got.pop_front() : 9'h1FF;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_byte%0d got=%h required=%h", i, g, e); end
    end
    q_got.delete();
    n_checks++;
    if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stall_stable got=%0d required=0", stall_viol); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    logic [31:0] d;
    logic [8:0] e, g;
    bit ok;
    tready = 1'b1;
    exp_push(32'hAABB_CCDD, 2, 1'b1);
    exp_push(32'h1122_3344, 4, 1'b1);
    axi_write(4'h8, 32'hAABB_CCDD, 4'hF, r);
    axi_write(4'h8, 32'h1122_3344, 4'hF, r);
    axi_write(4'hC, 32'd2, 4'hF, r);
    wait_bytes(2, 100, ok);
    repeat (3) @(posedge clk);
    axi_write(4'hC, 32'd4, 4'hF, r);
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL b2b_len2_resp got=%b required=00", r); end
    wait_bytes(6, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout got=%0d required=6 bytes", q_got.size()); end
    for (int i = 0; i < 6; i++) begin
      e = q_exp.pop_front();
      g = (q_got.size() > 0) ? q_got.pop_front() : 9'h1FF;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_byte%0d got=%h required=%h", i, g, e); end
    end
    repeat (3) @(posedge clk);
    axi_read(4'h4, d);
    n_checks++;
    if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL b2b_status got=%h required=00020000", d); end
  endtask

`ifdef ETH_AXI_TX_IRQ_EN
  task automatic test_irq();
    logic [1:0] r;
    logic [31:0] d;
    bit ok;
    tready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      axi_write(4'h0, (pass == 0) ? 32'h1 : 32'h5, 4'hF, r);
      if (pass == 1) begin
        axi_read(4'h0, d);
        n_checks++;
        if (d !== 32'h5) begin n_fail++; $display("FAIL irq_ctrl_read got=%h required=5", d); end
      end
      irq_good = 0; irq_bad = 0;
      axi_write(4'h8, 32'h0403_0201, 4'hF, r);
      axi_write(4'hC, 32'd4, 4'hF, r);
      wait_bytes(4, 100, ok);
      repeat (6) @(posedge clk);
      n_checks++;
      if (!ok || q_got.size() != 4) begin n_fail++; $display("FAIL irq_frame%0d got=%0d required=4 bytes", pass, q_got.size()); end
      q_got.delete();
      n_checks++;
      if (irq_good != ((pass == 0) ? 1 : 0) || irq_bad != 0) begin
        n_fail++; $display("FAIL irq_pulse%0d got=good%0d bad%0d required=good%0d bad0", pass, irq_good, irq_bad, (pass == 0) ? 1 : 0);
      end
    end
  endtask
`endif

  task automatic test_reset_abort();
    logic [1:0] r;
    logic [31:0] d;
    tready = 1'b0;
    axi_write(4'h0, 32'h1, 4'hF, r);
    axi_write(4'h8, 32'h7766_5544, 4'hF, r);
    axi_write(4'hC, 32'd4, 4'hF, r);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h44) begin
      n_fail++; $display("FAIL abort_stalled got=v%b d%h required=v1 d44", tvalid, tdata);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      n_fail++; $display("FAIL abort_async got=v%b l%b required=v0 l0", tvalid, tlast);
    end
    tready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    axi_read(4'h4, d);
    n_checks++;
    if (d !== 32'h0002_0000 || q_got.size() != 0) begin
      n_fail++; $display("FAIL abort_after got=%h bytes%0d required=00020000 bytes0", d, q_got.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fifo_full();
    test_len_pending_flush();
    test_backpressure();
    test_back_to_back();
`ifdef ETH_AXI_TX_IRQ_EN
    test_irq();
`endif
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
